pe_scalar_rf: RTL
=================

// Module: pe_scalar_rf
// PURPOSE
//  Parametrised scalar processing element for the CGRA tile: 2-stage pipelined ALU
//  with a private NREG-entry register file, operand forwarding and valid/ready flow.
//  Executes scalar control/address ops (lui/addi/add/sub/mov/branches) that feed the
//  vector PEs. Branch outcome returned on flag_branch. One instruction per cycle when unstalled.
// PARAMETERS
//  DWIDTH  32  datapath and register width
//  NREG    8   register-file entries (power of 2, >=2); r0 reads 0, writes ignored
//  OPW     4   opcode width
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 synchronous active-high reset
//  in_valid     in   1                 instruction valid
//  in_ready     out  1                 instruction accepted when in_valid & in_ready
//  op           in   OPW               opcode (encodings below)
//  rd           in   $clog2(NREG)      destination register
//  rs1, rs2     in   $clog2(NREG)      source registers
//  imm          in   DWIDTH            immediate
//  out_valid    out  1                 result valid
//  out_ready    in   1                 consumer ready
//  out_data     out  DWIDTH            ALU result (0 for branches/NOP)
//  flag_branch  out  1                 branch taken, qualified by out_valid
//  retired      out  32                count of instructions leaving the output register
// BEHAVIOUR
//  - Clock clk; reset rst is synchronous and active-high. Reset clears RF, S1, out
//    register, retired; out_valid=0, out_data=0, flag_branch=0, in_ready=1 after reset.
//    Reset mid-operation discards all in-flight instructions, no RF write.
//  - Opcodes: NOP=0, LUI=1 (rd={imm[DWIDTH/2-1:0],DWIDTH/2 zeros}), ADDI=2 (rs1+imm),
//    ADD=3 (rs1+rs2), SUB=4 (rs1-rs2), MOV=5 (rd=imm), BNE=6, BEQ=7, BLT=8 (signed
//    rs1<rs2). Undefined codes behave as NOP. Arithmetic wraps mod 2^DWIDTH.
//  - Branches and NOP: no RF write, out_data=0; flag_branch=1 iff condition true.
//  - S1: on accept, latch op/rd/imm and operand values (RF read + forwarding).
//    S2/output: ALU on S1, result into out register; RF write to rd at the same edge.
//  - Latency: accepted at edge t -> out_valid asserted after edge t+1 (2 edges).
//  - advance = !out_valid | out_ready; S1 moves to out reg on advance.
//    in_ready = !s1_valid | advance (combinational, no in_valid dependence).
//  - Stall: out_valid & !out_ready holds out_data/flag_branch stable; S1 holds.
//  - Forwarding: if accepting while S1 holds a writing op moving this edge with
//    rd==rs1/rs2 (rd!=0), take ALU result instead of RF. If S1 writing op is stalled,
//    RF is not yet written: accept is blocked anyway (in_ready=0), so no hazard.
//  - rs==0 always yields 0, including forwarding cases.
//  - retired increments when out_valid & out_ready; wraps at 2^32.
// STRUCTURE
//  - Shared package pe_scalar_pkg: op_e enum (OPW bits), ALU function alu_f(op,a,b,imm),
//    branch predicate br_f(op,a,b).
//  - One sub-module: pe_scalar_regfile (NREG x DWIDTH, 2 async read, 1 sync write,
//    sync clear on rst, r0 hardwired 0). ALU and pipeline control inline.
// TESTING
//  1. Reset: rst high 2 cycles -> out_valid=0, in_ready=1, retired=0, all RF reads 0.
//  2. MOV r1,5; ADDI r2,r1,3 back-to-back, out_ready=1 -> outputs 5 then 8 on
//     consecutive cycles (forwarding), retired=2.
//  3. LUI r3,imm=0x1234 (DWIDTH=32) -> out_data=0x12340000; SUB r4,r0,r1(=5) ->
//     0xFFFFFFFB (wrap).
//  4. r1=5,r2=8: BNE r1,r2 -> flag=1; BEQ -> 0; BLT r2,r1 -> 0; r5=-1, BLT r5,r1 -> 1;
//     no RF change.
//  5. out_ready=0 for 4 cycles with 3 instrs offered -> 2 held, in_ready=0, out_data
//     stable; release -> all 3 in order, none lost/duplicated.
//  6. rst asserted with S1 and out full -> out_valid=0 next cycle, rd of in-flight
//     op reads 0, retired=0.

Source files
------------

// File: rtl/pe_scalar_rf_pkg.sv
// Shared definitions for the scalar PE: opcode enum, ALU and branch helpers.
// Helpers operate on a wide internal word; callers sign-extend and truncate to their width.
package pe_scalar_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned XW   = 64;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_LUI  = 4'd1,
    OP_ADDI = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_MOV  = 4'd5,
    OP_BNE  = 4'd6,
    OP_BEQ  = 4'd7,
    OP_BLT  = 4'd8
  } op_e;

  function automatic logic writes_f(input op_e op);
    return op inside {OP_LUI, OP_ADDI, OP_ADD, OP_SUB, OP_MOV};
  endfunction

  // Result is masked to dw bits so wrap-around matches a dw-bit datapath.
  function automatic logic [XW-1:0] alu_f(input op_e op,
                                          input logic [XW-1:0] a,
                                          input logic [XW-1:0] b,
                                          input logic [XW-1:0] imm,
                                          input int unsigned dw);
    logic [XW-1:0] r;
    logic [XW-1:0] mask;
    r    = '0;
    mask = (dw >= XW) ? '1 : ((XW'(1) << dw) - XW'(1));
    case (op)
      OP_LUI:  r = imm << (dw / 2);
      OP_ADDI: r = a + imm;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MOV:  r = imm;
      default: r = '0;
    endcase
    return r & mask;
  endfunction

  function automatic logic br_f(input op_e op,
                                input logic [XW-1:0] a,
                                input logic [XW-1:0] b);
    logic t;
    t = 1'b0;
    case (op)
      OP_BNE:  t = (a != b);
      OP_BEQ:  t = (a == b);
      OP_BLT:  t = ($signed(a) < $signed(b));
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pe_scalar_rf_if.sv
// Instruction-in / result-out handshake bundle of the scalar PE.
interface pe_scalar_rf_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NREG   = 8,
  parameter int unsigned OPW    = 4
);
  localparam int unsigned AW = $clog2(NREG);

  logic              in_valid;
  logic              in_ready;
  logic [OPW-1:0]    op;
  logic [AW-1:0]     rd;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic [DWIDTH-1:0] imm;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              flag_branch;
  logic [31:0]       retired;

  modport master (
    output in_valid, op, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_data, flag_branch, retired
  );

  modport slave (
    input  in_valid, op, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_data, flag_branch, retired
  );

endinterface

// File: rtl/pe_scalar_rf_regfile.sv
// NREG x DWIDTH register file: two async reads, one sync write, r0 hardwired to zero.
module pe_scalar_regfile #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NREG   = 8,
  parameter int unsigned AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DWIDTH-1:0] wd
);

  logic [DWIDTH-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/pe_scalar_rf.sv
// Scalar PE: S1 operand latch -> ALU -> output register, with RF write-back and
// forwarding from the op leaving S1 into the op being accepted on the same edge.
module pe_scalar_rf
  import pe_scalar_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NREG   = 8,
  parameter int unsigned OPW    = 4
) (
  input logic            clk,
  input logic            rst,
  pe_scalar_rf_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREG);

  function automatic logic [XW-1:0] sx(input logic [DWIDTH-1:0] v);
    return {{(XW-DWIDTH){v[DWIDTH-1]}}, v};
  endfunction

  logic              s1_valid;
  op_e               s1_op;
  logic [AW-1:0]     s1_rd;
  logic [DWIDTH-1:0] s1_imm;
  logic [DWIDTH-1:0] s1_a;
  logic [DWIDTH-1:0] s1_b;

  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              flag_branch;
  logic [31:0]       retired;

  logic              advance;
  logic              in_ready;
  logic              accept;
  logic              s1_fire;
  logic              s1_writes;
  op_e               in_op;
  logic [XW-1:0]     alu_wide;
  logic [DWIDTH-1:0] alu_res;
  logic              br_taken;
  logic [DWIDTH-1:0] rf_a;
  logic [DWIDTH-1:0] rf_b;
  logic [DWIDTH-1:0] opnd_a;
  logic [DWIDTH-1:0] opnd_b;

  assign advance   = !out_valid || bus.out_ready;
  assign in_ready  = !s1_valid || advance;
  assign accept    = bus.in_valid && in_ready;
  assign s1_fire   = s1_valid && advance;
  assign s1_writes = s1_valid && writes_f(s1_op) && (s1_rd != '0);

  // Codes outside the defined set collapse to NOP at the input.
  always_comb begin
    in_op = OP_NOP;
    if (bus.op < OPW'(9)) in_op = op_e'(bus.op[OP_W-1:0]);
  end

  assign alu_wide = alu_f(s1_op, sx(s1_a), sx(s1_b), sx(s1_imm), DWIDTH);
  assign alu_res  = alu_wide[DWIDTH-1:0];
  assign br_taken = br_f(s1_op, sx(s1_a), sx(s1_b));

  if (DWIDTH < XW) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^alu_wide[XW-1:DWIDTH];
  end

  pe_scalar_regfile #(
    .DWIDTH (DWIDTH),
    .NREG   (NREG)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (bus.rs1),
    .ra2 (bus.rs2),
    .rd1 (rf_a),
    .rd2 (rf_b),
    .we  (s1_fire && s1_writes),
    .wa  (s1_rd),
    .wd  (alu_res)
  );

  // RF write and the next accept share an edge, so the leaving result bypasses the RF.
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (s1_fire && s1_writes && (s1_rd == bus.rs1)) opnd_a = alu_res;
    if (s1_fire && s1_writes && (s1_rd == bus.rs2)) opnd_b = alu_res;
    if (bus.rs1 == '0) opnd_a = '0;
    if (bus.rs2 == '0) opnd_b = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_op       <= OP_NOP;
      s1_rd       <= '0;
      s1_imm      <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      flag_branch <= 1'b0;
      retired     <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= in_op;
        s1_rd    <= bus.rd;
        s1_imm   <= bus.imm;
        s1_a     <= opnd_a;
        s1_b     <= opnd_b;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (advance) begin
        out_valid   <= s1_valid;
        out_data    <= s1_valid ? alu_res : '0;
        flag_branch <= s1_valid && br_taken;
      end

      if (out_valid && bus.out_ready) retired <= retired + 32'd1;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.flag_branch = flag_branch;
  assign bus.retired     = retired;

endmodule
